coord_wb_sequencer: RTL and testbench

COORD_WB_SEQUENCER -- requirements
Module: coord_wb_sequencer

---
 rtl/coord_wb_sequencer.sv | 124 ++++++++++++
 tb/tb_coord_wb_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/coord_wb_sequencer.sv
// Buffers coordinate results {X, Y, Rd} and replays each one as two register-file
// writes (Rd <- X, Rd+1 <- Y) whenever the main pipeline leaves the write port free.
module coord_wb_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [4:0]  in_rd,
    output logic        in_ready,
    input  logic        port_busy,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        busy,
    output logic        overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [4:0]  rd;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_X,
        WR_Y
    } state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          wr_go;
    logic [4:0]    wr_addr;
    logic [15:0]   wr_data;

    // Readiness comes from the registered count only, so a full buffer refuses
    // a push even on the edge where the head is popped.
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == WR_Y) && !port_busy;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // NOTE: storage carries no reset; count and pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{x: in_x, y: in_y, rd: in_rd};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = WR_X;
                end
            end
            WR_X: begin
                if (!port_busy) begin
                    wr_go     = 1'b1;
                    wr_addr   = head.rd;
                    wr_data   = head.x;
                    state_nxt = WR_Y;
                end
            end
            WR_Y: begin
                if (!port_busy) begin
                    wr_go     = 1'b1;
                    wr_addr   = head.rd + 5'd1;
                    wr_data   = head.y;
                    state_nxt = (count_nxt != '0) ? WR_X : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // r0 is hardwired: its beat still takes a cycle but never asserts the enable.
        wb_en   = wr_go && (wr_addr != 5'd0);
        wb_addr = wb_en ? wr_addr : 5'd0;
        wb_data = wb_en ? wr_data : 16'd0;
    end
endmodule

// File: tb/tb_coord_wb_sequencer.sv
// Directed bench for coord_wb_sequencer: a queue-of-write-beats model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_coord_wb_sequencer;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [4:0]  in_rd;
    logic        in_ready;
    logic        port_busy;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    coord_wb_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_rd     (in_rd),
        .in_ready  (in_ready),
        .port_busy (port_busy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each accepted entry becomes two pending write beats; writing starts
    // one edge after the buffer is seen non-empty and continues while beats remain.
    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
    } beat_t;

    beat_t m_beats[$];
    logic  m_started;
    logic  m_ovf;

    function automatic int m_occ();
        return (m_beats.size() + 1) / 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beats.delete();
            m_started <= 1'b0;
            m_ovf     <= 1'b0;
        end else begin : upd
            int occ;
            occ = m_occ();
            if (m_started && m_beats.size() > 0 && !port_busy) begin
                void'(m_beats.pop_front());
            end
            if (in_valid) begin
                if (occ < DEPTH) begin
                    m_beats.push_back('{addr: in_rd, data: in_x});
                    m_beats.push_back('{addr: 5'(in_rd + 5'd1), data: in_y});
                end else begin
                    m_ovf <= 1'b1;
                end
            end
            m_started <= m_started ? (m_beats.size() > 0) : (occ > 0);
        end
    end

    function automatic logic [24:0] model_out();
        logic        en;
        logic [4:0]  a;
        logic [15:0] d;
        en = 1'b0;
        a  = 5'd0;
        d  = 16'd0;
        if (m_started && m_beats.size() > 0 && !port_busy && m_beats[0].addr != 5'd0) begin
            en = 1'b1;
            a  = m_beats[0].addr;
            d  = m_beats[0].data;
        end
        return {en, a, d, m_occ() < DEPTH, (m_occ() > 0) || m_started, m_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model", {7'd0, wb_en, wb_addr, wb_data, in_ready, busy, overflow}, {7'd0, model_out()});
    end

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [4:0] rd);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_rd    = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_wb(input string name, input logic en, input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        check(name, {10'd0, en ? 1'b1 : 1'b0, a, d} & 32'h3fffff | 32'h0, {10'd0, en, a, d});
        check(name, {10'd0, wb_en, wb_addr, wb_data}, {10'd0, en, a, d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_rd     = '0;
        port_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {wb_en, wb_addr, wb_data, in_ready, busy, overflow}, {1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single entry: r8 <- 5 two cycles after the push edge, r9 <- 3 the next.
        push(16'd5, 16'd3, 5'd8);
        check("t1_busy_after_push", busy, 1);
        expect_wb("t1_idle", 1'b0, 5'd0, 16'd0);
        expect_wb("t1_x", 1'b1, 5'd8, 16'd5);
        expect_wb("t1_y", 1'b1, 5'd9, 16'd3);
        check("t1_busy_done", busy, 0);

        // Rd=31: Y targets r0 (wrapped), which is suppressed but still consumed.
        push(16'd63, 16'd1023, 5'd31);
        expect_wb("t2_idle", 1'b0, 5'd0, 16'd0);
        expect_wb("t2_x", 1'b1, 5'd31, 16'd63);
        expect_wb("t2_y_r0", 1'b0, 5'd0, 16'd0);
        check("t2_busy_done", busy, 0);

        // Port held by the pipeline for 4 cycles in the middle of a sequence.
        push(16'd7, 16'd9, 5'd4);
        expect_wb("t3_idle", 1'b0, 5'd0, 16'd0);
        port_busy = 1'b1;
        for (int i = 0; i < 4; i++) expect_wb("t3_stall", 1'b0, 5'd0, 16'd0);
        port_busy = 1'b0;
        expect_wb("t3_x", 1'b1, 5'd4, 16'd7);
        expect_wb("t3_y", 1'b1, 5'd5, 16'd9);
        check("t3_busy_done", busy, 0);

        // Three back-to-back pushes into a DEPTH=2 buffer while the port is busy.
        port_busy = 1'b1;
        push(16'd1, 16'd2, 5'd2);
        check("t4_ready_after_1", in_ready, 1);
        push(16'd3, 16'd4, 5'd10);
        check("t4_ready_after_2", in_ready, 0);
        push(16'd5, 16'd6, 5'd20);
        check("t4_overflow", overflow, 1);
        port_busy = 1'b0;
        expect_wb("t4_a_x", 1'b1, 5'd2, 16'd1);
        expect_wb("t4_a_y", 1'b1, 5'd3, 16'd2);
        expect_wb("t4_b_x", 1'b1, 5'd10, 16'd3);
        expect_wb("t4_b_y", 1'b1, 5'd11, 16'd4);
        check("t4_busy_done", busy, 0);
        check("t4_overflow_sticky", overflow, 1);

        // Synchronous-looking reset pulse clears the sticky flag.
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_clears_overflow", overflow, 0);

        // Push against a full buffer on the edge where the head's Y write pops.
        port_busy = 1'b1;
        push(16'd100, 16'd200, 5'd12);
        push(16'd300, 16'd400, 5'd14);
        port_busy = 1'b0;
        expect_wb("t5_d_x", 1'b1, 5'd12, 16'd100);
        in_valid = 1'b1;
        in_x     = 16'd500;
        in_y     = 16'd600;
        in_rd    = 5'd20;
        #1;
        check("t5_ready_full", in_ready, 0);
        expect_wb("t5_d_y", 1'b1, 5'd13, 16'd200);
        in_valid = 1'b0;
        check("t5_overflow", overflow, 1);
        check("t5_ready_one_left", in_ready, 1);
        expect_wb("t5_e_x", 1'b1, 5'd14, 16'd300);
        expect_wb("t5_e_y", 1'b1, 5'd15, 16'd400);
        check("t5_busy_done", busy, 0);

        // Asynchronous reset between the X and Y writes discards the Y write.
        push(16'd11, 16'd22, 5'd6);
        expect_wb("t6_idle", 1'b0, 5'd0, 16'd0);
        expect_wb("t6_x", 1'b1, 5'd6, 16'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_outputs", {wb_en, wb_addr, wb_data, in_ready, busy, overflow}, {1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_wb("t6_no_write", 1'b0, 5'd0, 16'd0);
        check("t6_after_release", {in_ready, busy, overflow}, {1'b1, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
